// File: rtl/vga_out_sched_pkg.sv
// Shared types for the VGA output sequencer.
//   state_t     : sequencer states (RUN, PEND, MUTE_PRE, MUTE_POST)
//   cfg_t       : converter configuration {en, full}
//   FRAME_CNT_W : width of the post-mute frame counter (MUTE_FRAMES 0..15)
package vga_out_sched_pkg;

  localparam int FRAME_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    MUTE_PRE,
    MUTE_POST
  } state_t;

  typedef struct packed {
    logic en;
    logic full;
  } cfg_t;

endpackage

// File: rtl/vga_vs_tick.sv
// Frame tick generator.
//   clk, reset : video clock, synchronous active-high reset
//   vs_in      : active-high vertical sync
//   tk         : one-clock pulse on each rising edge of the registered vsync,
//                or after TO_CYCLES clocks without one (stopped video)
module vga_vs_tick #(
  parameter int TO_CYCLES = 4000000
) (
  input  logic clk,
  input  logic reset,
  input  logic vs_in,
  output logic tk
);

  localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  logic             vs_q;
  logic             vs_q_d;
  logic [CNT_W-1:0] to_cnt;

  // Counter restarts on every tick, so the synthetic tick only fires when
  // real vsync edges have stopped arriving.
  assign tk = (vs_q & ~vs_q_d) | (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q   <= 1'b0;
      vs_q_d <= 1'b0;
      to_cnt <= '0;
    end else begin
      vs_q   <= vs_in;
      vs_q_d <= vs_q;
      to_cnt <= tk ? '0 : to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_out_sched.sv
// VGA output sequencer around the RGB->YPbPr converter.
// Applies YPbPr mode requests only at frame boundaries and keeps the picture
// black for MUTE_FRAMES frames around each switch.
//   clk, reset            : video clock, synchronous active-high reset
//   req_en, req_full      : requested converter config (clk domain)
//   din, hs_in/vs_in/de_in: RGB pixel and timing in
//   conv_din / conv_dout  : registered pixel to converter / converter result
//   ypbpr_en, ypbpr_full  : active config driven to the converter
//   dout, hs/vs/de_out    : registered output, timing matched (2 clocks)
//   muted                 : picture forced black
//   busy                  : sequencer not in RUN
module vga_out_sched
  import vga_out_sched_pkg::*;
#(
  parameter int MUTE_FRAMES = 2,
  parameter int TO_CYCLES   = 4000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_en,
  input  logic        req_full,
  input  logic [23:0] din,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [23:0] conv_din,
  input  logic [23:0] conv_dout,
  output logic        ypbpr_en,
  output logic        ypbpr_full,
  output logic [23:0] dout,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        muted,
  output logic        busy
);

  state_t                 state;
  cfg_t                   active_cfg;
  cfg_t                   pend_cfg;
  cfg_t                   req_cfg;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   tk;
  logic                   diff;
  logic                   hs_d1;
  logic                   vs_d1;
  logic                   de_d1;

  vga_vs_tick #(
    .TO_CYCLES(TO_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .vs_in (vs_in),
    .tk    (tk)
  );

  assign req_cfg    = {req_en, req_full};
  assign diff       = (req_cfg != active_cfg);
  assign muted      = (state == MUTE_PRE) || (state == MUTE_POST);
  assign busy       = (state != RUN);
  assign ypbpr_en   = active_cfg.en;
  assign ypbpr_full = active_cfg.full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      active_cfg <= '0;
      pend_cfg   <= '0;
      frame_cnt  <= '0;
    end else begin
      if (state != RUN) pend_cfg <= req_cfg;
      case (state)
        RUN: begin
          if (diff) state <= PEND;
        end
        PEND: begin
          if (!diff)   state <= RUN;
          else if (tk) state <= MUTE_PRE;
        end
        MUTE_PRE: begin
          if (tk) begin
            active_cfg <= pend_cfg;
            if (MUTE_FRAMES == 0) begin
              state <= RUN;
            end else begin
              frame_cnt <= FRAME_CNT_W'(MUTE_FRAMES);
              state     <= MUTE_POST;
            end
          end
        end
        MUTE_POST: begin
          // A fresh request restarts the whole mute sequence.
          if (diff) begin
            state <= MUTE_PRE;
          end else if (tk) begin
            frame_cnt <= frame_cnt - 1'b1;
            if (frame_cnt == FRAME_CNT_W'(1)) state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Black is inserted ahead of the converter so it is coded for the active mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_din <= '0;
      hs_d1    <= 1'b0;
      vs_d1    <= 1'b0;
      de_d1    <= 1'b0;
      dout     <= '0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
      de_out   <= 1'b0;
    end else begin
      conv_din <= muted ? 24'h0 : din;
      hs_d1    <= hs_in;
      vs_d1    <= vs_in;
      de_d1    <= de_in;
      dout     <= conv_dout;
      hs_out   <= hs_d1;
      vs_out   <= vs_d1;
      de_out   <= de_d1;
    end
  end

endmodule

// File: tb/tb_vga_out_sched.sv
module tb_vga_out_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_en, req_full;
  logic [23:0] din;
  logic        hs_in, vs_in, de_in;
  logic [23:0] conv_din, conv_dout;
  logic        ypbpr_en, ypbpr_full;
  logic [23:0] dout;
  logic        hs_out, vs_out, de_out;
  logic        muted, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Identity stand-in for the converter.
  assign conv_dout = conv_din;

  vga_out_sched #(
    .MUTE_FRAMES(2),
    .TO_CYCLES  (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_en     (req_en),
    .req_full   (req_full),
    .din        (din),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .conv_din   (conv_din),
    .conv_dout  (conv_dout),
    .ypbpr_en   (ypbpr_en),
    .ypbpr_full (ypbpr_full),
    .dout       (dout),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .de_out     (de_out),
    .muted      (muted),
    .busy       (busy)
  );

  typedef struct {
    logic [23:0] din;
    logic        hs, vs, de;
    logic [23:0] exp_dout;
    logic        exp_hs, exp_vs, exp_de;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vs_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_frame();
    vs_in = 1'b1;
    repeat (4) step();
    vs_in = 1'b0;
    repeat (36) step();
  endtask

  initial begin
    vecs[0] = '{24'h123456, 1'b0, 1'b0, 1'b1, 24'h123456, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{24'hABCDEF, 1'b1, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{24'h000000, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{24'hFFFFFF, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{24'h800001, 1'b0, 1'b0, 1'b1, 24'h800001, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{24'h5A5A5A, 1'b1, 1'b0, 1'b0, 24'h5A5A5A, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{24'h0F0F0F, 1'b0, 1'b1, 1'b1, 24'h0F0F0F, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{24'h123456, 1'b1, 1'b1, 1'b1, 24'h123456, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; req_en = 1'b0; req_full = 1'b0;
    din = 24'h0; hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;

    // 1. Reset state and 2-clock pipeline
    do_reset();
    chk("rst_dout", dout, 24'h0);
    chk("rst_conv_din", conv_din, 24'h0);
    chk("rst_busy", busy, 0);
    chk("rst_muted", muted, 0);
    chk("rst_cfg", {ypbpr_en, ypbpr_full}, 0);
    for (int j = 0; j < 9; j++) begin
      if (j < 8) begin
        din = vecs[j].din; hs_in = vecs[j].hs; vs_in = vecs[j].vs; de_in = vecs[j].de;
      end
      step();
      if (j < 8) chk("pipe_conv_din", conv_din, vecs[j].din);
      if (j >= 1) begin
        chk("pipe_dout", dout, vecs[j-1].exp_dout);
        chk("pipe_sync", {hs_out, vs_out, de_out},
            {vecs[j-1].exp_hs, vecs[j-1].exp_vs, vecs[j-1].exp_de});
      end
      chk("pipe_busy", busy, 0);
    end

    // 2. Enable request, two-frame post-mute
    din = 24'hABCDEF; hs_in = 1'b0; de_in = 1'b1; vs_in = 1'b0;
    do_reset();
    repeat (5) step();
    req_en = 1'b1;
    step();
    chk("t2_pend_busy", busy, 1);
    repeat (8) step();
    chk("t2_pend_muted", muted, 0);
    vs_in = 1'b1;
    step();
    chk("t2_edge_muted_early", muted, 0);
    step();
    chk("t2_edge_muted", muted, 1);
    step();
    chk("t2_black", conv_din, 24'h0);
    step();
    vs_in = 1'b0;
    repeat (36) step();
    chk("t2_f1_en", ypbpr_en, 0);
    chk("t2_f1_black", dout, 24'h0);
    run_frame();
    chk("t2_f2_muted", muted, 1);
    chk("t2_f2_en", ypbpr_en, 1);
    chk("t2_f2_black", conv_din, 24'h0);
    run_frame();
    chk("t2_f3_muted", muted, 1);
    chk("t2_f3_black", conv_din, 24'h0);
    run_frame();
    chk("t2_f4_muted", muted, 0);
    chk("t2_f4_busy", busy, 0);
    chk("t2_f4_en", ypbpr_en, 1);
    chk("t2_f4_pix", conv_din, 24'hABCDEF);
    req_en = 1'b0;

    // 3. Request glitch withdrawn before a frame edge
    do_reset();
    repeat (3) step();
    req_en = 1'b1;
    step();
    chk("t3_busy_pend", busy, 1);
    req_en = 1'b0;
    step();
    chk("t3_busy_run", busy, 0);
    run_frame();
    chk("t3_muted", muted, 0);
    chk("t3_en", ypbpr_en, 0);

    // 4. New full request during post-mute restarts the sequence
    do_reset();
    req_en = 1'b1;
    step();
    run_frame();
    run_frame();
    chk("t4_post_cfg", {ypbpr_en, ypbpr_full}, 2'b10);
    req_full = 1'b1;
    step();
    chk("t4_repre_muted", muted, 1);
    chk("t4_repre_full", ypbpr_full, 0);
    run_frame();
    chk("t4_apply_cfg", {ypbpr_en, ypbpr_full}, 2'b11);
    chk("t4_apply_muted", muted, 1);
    run_frame();
    chk("t4_post1_muted", muted, 1);
    run_frame();
    chk("t4_done_muted", muted, 0);
    chk("t4_done_busy", busy, 0);
    req_full = 1'b0; req_en = 1'b0;

    // 5. Stopped video: timeout ticks every 100 clocks
    do_reset();
    req_en = 1'b1;
    repeat (99) step();
    chk("t5_99_muted", muted, 0);
    chk("t5_99_busy", busy, 1);
    step();
    chk("t5_100_muted", muted, 1);
    repeat (99) step();
    chk("t5_199_en", ypbpr_en, 0);
    step();
    chk("t5_200_en", ypbpr_en, 1);
    repeat (199) step();
    chk("t5_399_muted", muted, 1);
    step();
    chk("t5_400_muted", muted, 0);
    chk("t5_400_busy", busy, 0);
    req_en = 1'b0;

    // 6. Reset while in MUTE_POST
    do_reset();
    req_en = 1'b1;
    step();
    run_frame();
    run_frame();
    chk("t6_post_muted", muted, 1);
    hs_in = 1'b1; de_in = 1'b1; vs_in = 1'b1;
    reset = 1'b1;
    step();
    chk("t6_rst_outs", {conv_din, dout, hs_out, vs_out, de_out, ypbpr_en, ypbpr_full, muted, busy}, 0);
    reset = 1'b0;
    step();
    chk("t6_redetect_busy", busy, 1);
    chk("t6_redetect_muted", muted, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_out_sched.md
Name: vga_out_sched

Overview:
- Sequencing controller wrapped around the combinational RGB→YPbPr converter on the analog VGA output path.
- Takes the user's YPbPr mode requests, which are asynchronous to video, and applies them to the converter only at frame boundaries.
- Mutes the picture for a programmable number of frames around each switch so the monitor never sees a torn or mis-coded frame.
- Owns a 2-stage register pipeline: into the converter, then out of it, with matched sync delay.

Parameters:
- MUTE_FRAMES, 2, whole frames kept black after a new config is applied (0..15).
- TO_CYCLES, 4000000, clocks without a vsync rising edge before a synthetic frame tick is generated (handles stopped video).

Ports:
- clk  in  1  video clock.
- reset  in  1  synchronous, active-high.
- req_en  in  1  requested ypbpr_en (quasi-static, already in clk domain).
- req_full  in  1  requested ypbpr_full.
- din  in  24  RGB pixel {R,G,B}.
- hs_in, vs_in, de_in  in  1 each  input timing; vs active-high.
- conv_din  out  24  registered pixel to converter.
- conv_dout  in  24  converter result.
- ypbpr_en, ypbpr_full  out  1 each  active config to converter.
- dout  out  24  registered converter output.
- hs_out, vs_out, de_out  out  1 each  timing delayed to match dout.
- muted  out  1  status, high while picture is forced black.
- busy  out  1  high in any state other than RUN.

Behaviour:
- Reset: state RUN; every output 0; active cfg {en,full}=00; frame counter 0; timeout counter 0.
- Pipeline, every clock:
  - Stage 1: conv_din <= muted ? 24'h0 : din; sync signals delayed one clock.
  - Stage 2: dout <= conv_dout; sync signals delayed again.
  - din to dout latency is exactly 2 clocks.
  - Mute is applied before the converter, so black is coded correctly in either mode (Y=16, Pb=Pr=128 in YPbPr).
- Frame tick (tk), generated by sub-module:
  - tk = 1-clock pulse on the rising edge of registered vs_in.
  - Also pulses when the timeout counter reaches TO_CYCLES-1. The counter clears on any tk and counts in every state.
- Request detect: diff = ({req_en,req_full} != active cfg). pend_cfg is sampled every clock from the req inputs while not in RUN; the latest request wins.
- RUN:
  - If diff: go to PEND; muted stays 0.
- PEND:
  - If !diff: return to RUN with no mute.
  - On tk: go to MUTE_PRE and set muted=1.
- MUTE_PRE:
  - On tk: active cfg <= pend_cfg; ypbpr_en/ypbpr_full update on that same edge.
  - If MUTE_FRAMES==0: go to RUN and clear muted.
  - Otherwise: frame counter <= MUTE_FRAMES; go to MUTE_POST.
- MUTE_POST:
  - If diff: go to MUTE_PRE; muted stays 1; frame counter is discarded.
  - Else on tk: decrement the counter. At counter==1, go to RUN and clear muted.
- Simultaneous events: in MUTE_POST, diff has priority over tk.
- Config stability: ypbpr_en/ypbpr_full change only on the MUTE_PRE→tk edge, so they are stable for a full muted frame before and after each change.
- Reset mid-sequence: returns immediately to the reset state; the unapplied request is re-detected in RUN on the next clock.
- Outputs are registered, with no combinational path from input to output. muted and busy come straight from state.

Decomposition:
- Package vga_out_sched_pkg:
  - state enum {RUN, PEND, MUTE_PRE, MUTE_POST}.
  - cfg struct {en, full}.
  - FRAME_CNT_W = 4.
- Sub-module vga_vs_tick: vs edge detector plus TO_CYCLES timeout counter, outputs tk.

Test Plan:
1. Reset with req=00, pixels 0x123456 → dout=0x123456 two clocks after din; hs/vs/de delayed by 2; busy=0.
2. Set req_en=1 mid-frame, MUTE_FRAMES=2 → muted at the 1st vs edge; ypbpr_en=1 at the 2nd; muted clears at the 4th; conv_din=0 throughout the mute.
3. req_en pulses 0→1→0 before the next vs edge → back to RUN; muted never asserts; ypbpr_en stays 0.
4. Change req_full during MUTE_POST → re-enter MUTE_PRE; new full applied at the next tk; then a full 2-frame post-mute.
5. Hold vs_in=0 with TO_CYCLES=100 and request en=1 → muted after 100 clocks, cfg applied after 200, RUN after 400.
6. Assert reset in MUTE_POST → next clock: all outputs 0, state RUN; re-detect of the held request → PEND one clock after reset is released.
